// File: rtl/if_id_skid_buffer.sv
// Two-entry IF/ID buffer between fetch and decode. Head register drives decode
// directly; tail register absorbs one cycle of decode back-pressure.
module if_id_skid_buffer #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               if_valid,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic [ADDR_W-1:0]  if_pc,
  input  logic [ADDR_W-1:0]  if_newaddr,
  output logic               if_ready,
  input  logic               flush,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_newaddr,
  input  logic               id_ready,
  output logic [1:0]         occupancy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and if_ready depends only on state.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t state_q, state_d;

  logic [INSTR_W-1:0] head_instr, tail_instr;
  logic [ADDR_W-1:0]  head_pc, tail_pc;
  logic [ADDR_W-1:0]  head_newaddr, tail_newaddr;

  logic push, pop;
  logic head_load, head_shift, tail_load, clear;

  assign push = if_valid & if_ready;
  assign pop  = id_valid & id_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Flush wins over everything; in TWO no push can happen since if_ready=0.
  always_comb begin
    state_d    = state_q;
    head_load  = 1'b0;
    head_shift = 1'b0;
    tail_load  = 1'b0;
    clear      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
      clear   = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_load = 1'b1;
          end else if (push) begin
            tail_load = 1'b1;
            state_d   = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_shift = 1'b1;
            state_d    = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          clear   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_instr   <= '0;
      head_pc      <= '0;
      head_newaddr <= '0;
    end else if (clear) begin
      head_instr   <= '0;
      head_pc      <= '0;
      head_newaddr <= '0;
    end else if (head_load) begin
      head_instr   <= if_instr;
      head_pc      <= if_pc;
      head_newaddr <= if_newaddr;
    end else if (head_shift) begin
      head_instr   <= tail_instr;
      head_pc      <= tail_pc;
      head_newaddr <= tail_newaddr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tail_instr   <= '0;
      tail_pc      <= '0;
      tail_newaddr <= '0;
    end else if (clear) begin
      tail_instr   <= '0;
      tail_pc      <= '0;
      tail_newaddr <= '0;
    end else if (tail_load) begin
      tail_instr   <= if_instr;
      tail_pc      <= if_pc;
      tail_newaddr <= if_newaddr;
    end
  end

  // Head data stays in place after the last pop; id_valid qualifies it.
  assign id_instr   = head_instr;
  assign id_pc      = head_pc;
  assign id_newaddr = head_newaddr;
  assign id_valid   = (state_q != EMPTY);
  assign if_ready   = (state_q != TWO);

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule
